// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: opcodes, widths, program bases, fetch FSM states.
package mips_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_JUMP  = 6'b010000;

   localparam int PROG0_BASE = 1;   // fibonacci
   localparam int PROG1_BASE = 15;  // factorial
   localparam int PROG2_BASE = 30;  // synthetic
   localparam int PC_LIMIT   = 80;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, latches the memory word into the
// instruction register, resolves jumps locally and takes branch redirects.
module fetch_unit #(
   parameter int ADDR_W     = mips_pkg::ADDR_W,
   parameter int DATA_W     = mips_pkg::DATA_W,
   parameter int PROG0_BASE = mips_pkg::PROG0_BASE,
   parameter int PROG1_BASE = mips_pkg::PROG1_BASE,
   parameter int PROG2_BASE = mips_pkg::PROG2_BASE,
   parameter int PC_LIMIT   = mips_pkg::PC_LIMIT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        prog_sel,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] instrucao,
   output logic [DATA_W-1:0] instr_out,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic              busy,
   output logic              sel_err
);

   import mips_pkg::*;

   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PC_LIMIT);

   fetch_state_t      state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx;
   logic [DATA_W-1:0] instr_nx;
   logic [ADDR_W-1:0] pc_out_nx;
   logic              valid_nx;
   logic              sel_err_nx;
   logic [ADDR_W-1:0] jump_tgt;
   logic [5:0]        opcode;

   assign address  = pc;
   assign busy     = (state == RUN);
   assign jump_tgt = instrucao[ADDR_W-1:0];
   assign opcode   = instrucao[DATA_W-1:DATA_W-6];

   // Next-state and next-pc selection; priority inside RUN is redirect, stall, halt word, jump, fetch.
   always_comb begin
      // NOTE: every output of this block gets a hold value first so no path leaves one unassigned (no latches).
      state_nx   = state;
      pc_nx      = pc;
      instr_nx   = instr_out;
      pc_out_nx  = pc_out;
      valid_nx   = instr_valid;
      sel_err_nx = sel_err;
      case (state)
         IDLE, HALTED: begin
            valid_nx = 1'b0;
            if (start) begin
               if (prog_sel == 2'd3) begin
                  sel_err_nx = 1'b1;
               end else begin
                  sel_err_nx = 1'b0;
                  state_nx   = RUN;
                  case (prog_sel)
                     2'd0:    pc_nx = ADDR_W'(PROG0_BASE);
                     2'd1:    pc_nx = ADDR_W'(PROG1_BASE);
                     default: pc_nx = ADDR_W'(PROG2_BASE);
                  endcase
               end
            end
         end
         RUN: begin
            if (redirect_valid) begin
               pc_nx    = redirect_addr;
               valid_nx = 1'b0;
               if (redirect_addr > LIMIT) state_nx = HALTED;
            end else if (stall) begin
               // everything holds
            end else if (instrucao == '0) begin
               valid_nx = 1'b0;
               state_nx = HALTED;
            end else if (opcode == OPC_JUMP) begin
               pc_nx    = jump_tgt;
               valid_nx = 1'b0;
               if (jump_tgt > LIMIT) state_nx = HALTED;
            end else begin
               instr_nx  = instrucao;
               pc_out_nx = pc;
               valid_nx  = 1'b1;
               if (pc == LIMIT) state_nx = HALTED;
               else             pc_nx    = pc + ADDR_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
         end
      endcase
   end

   // State and fetch registers; asynchronous reset clears all of them at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= '0;
         instr_out   <= '0;
         pc_out      <= '0;
         instr_valid <= 1'b0;
         sel_err     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state       <= state_nx;
         pc          <= pc_nx;
         instr_out   <= instr_nx;
         pc_out      <= pc_out_nx;
         instr_valid <= valid_nx;
         sel_err     <= sel_err_nx;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small combinational instruction memory model.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  prog_sel = 2'd0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [9:0]  redirect_addr = 10'd0;
   logic [9:0]  address;
   logic [31:0] instrucao;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic [9:0]  pc_out;
   logic        busy;
   logic        sel_err;

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .prog_sel       (prog_sel),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .address        (address),
      .instrucao      (instrucao),
      .instr_out      (instr_out),
      .instr_valid    (instr_valid),
      .pc_out         (pc_out),
      .busy           (busy),
      .sel_err        (sel_err)
   );

   always #5 clock = ~clock;

   // Memory image: word 1 is the first fibonacci instruction, word 24 jumps to 21,
   // word 36 is the halt word; every other word is a non-jump ld tagged with its address.
   function automatic logic [31:0] mem(input logic [9:0] a);
      if (a == 10'd1)  return 32'h8C1F0001;
      if (a == 10'd24) return 32'h40000015;
      if (a == 10'd36) return 32'h00000000;
      return 32'h8C000000 | {22'd0, a};
   endfunction

   always_comb instrucao = mem(address);

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start(input logic [1:0] sel);
      start    = 1'b1;
      prog_sel = sel;
      step();
      start    = 1'b0;
   endtask

   task automatic quiet_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #3;
      checks++; if (address !== 10'd0)     begin errors++; $display("FAIL reset_address got %0d want 0", address); end
      checks++; if (instr_out !== 32'd0)   begin errors++; $display("FAIL reset_instr got %h want 0", instr_out); end
      checks++; if (instr_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
      checks++; if (pc_out !== 10'd0)      begin errors++; $display("FAIL reset_pc_out got %0d want 0", pc_out); end
      checks++; if (busy !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b sel_err=%b want 0 0", busy, sel_err); end
      @(negedge clock);
      reset = 1'b1;
      step();
   endtask

   // Program 0 start, latency and sequential fetch up to address 8.
   task automatic test_prog0();
      pulse_start(2'd0);
      checks++; if (address !== 10'd1)    begin errors++; $display("FAIL p0_first_addr got %0d want 1", address); end
      checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL p0_busy got %b want 1", busy); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL p0_valid_latency got %b want 0", instr_valid); end
      step();
      checks++; if (instr_out !== 32'h8C1F0001) begin errors++; $display("FAIL p0_first_instr got %h want 8c1f0001", instr_out); end
      checks++; if (pc_out !== 10'd1 || instr_valid !== 1'b1) begin errors++; $display("FAIL p0_first_pc got pc_out=%0d valid=%b want 1 1", pc_out, instr_valid); end
      checks++; if (address !== 10'd2)    begin errors++; $display("FAIL p0_addr2 got %0d want 2", address); end
      for (int i = 2; i < 8; i++) begin
         step();
         checks++;
         if (address !== 10'(i + 1) || pc_out !== 10'(i) || instr_out !== (32'h8C000000 | i) || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL p0_seq got addr=%0d pc_out=%0d instr=%h want %0d %0d", address, pc_out, instr_out, i + 1, i);
         end
      end
   endtask

   // Redirect at pc=8 with stall also high: the redirect wins and squashes.
   task automatic test_redirect_stall();
      checks++; if (address !== 10'd8) begin errors++; $display("FAIL rd_setup got %0d want 8", address); end
      stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 10'd61;
      step();
      stall = 1'b0; redirect_valid = 1'b0;
      checks++; if (address !== 10'd61)   begin errors++; $display("FAIL rd_addr got %0d want 61", address); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_squash got %b want 0", instr_valid); end
      step();
      checks++; if (pc_out !== 10'd61 || instr_out !== 32'h8C00003D || instr_valid !== 1'b1 || address !== 10'd62) begin
         errors++; $display("FAIL rd_resume got pc_out=%0d instr=%h addr=%0d want 61 8c00003d 62", pc_out, instr_out, address); end
   endtask

   // Three stall cycles freeze everything, then fetch resumes without skip or duplicate.
   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (address !== 10'd62 || pc_out !== 10'd61 || instr_out !== 32'h8C00003D || instr_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold got addr=%0d pc_out=%0d instr=%h want 62 61 8c00003d", address, pc_out, instr_out);
         end
      end
      stall = 1'b0;
      step();
      checks++; if (pc_out !== 10'd62 || address !== 10'd63) begin errors++; $display("FAIL stall_resume got pc_out=%0d addr=%0d want 62 63", pc_out, address); end
      // start while running is ignored
      pulse_start(2'd1);
      checks++; if (address !== 10'd64) begin errors++; $display("FAIL start_in_run got %0d want 64", address); end
   endtask

   task automatic test_async_reset();
      reset = 1'b0;
      #1;
      checks++; if (address !== 10'd0 || instr_out !== 32'd0 || pc_out !== 10'd0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL async_reset got addr=%0d instr=%h pc_out=%0d valid=%b busy=%b want all 0", address, instr_out, pc_out, instr_valid, busy); end
      @(negedge clock);
      reset = 1'b1;
      step();
      checks++; if (busy !== 1'b0 || address !== 10'd0) begin errors++; $display("FAIL idle_after_reset got busy=%b addr=%0d want 0 0", busy, address); end
   endtask

   // Program 1 reaches the jump at 24 and loops back to 21 with one bubble.
   task automatic test_jump();
      pulse_start(2'd1);
      for (int i = 15; i < 24; i++) begin
         checks++; if (address !== 10'(i)) begin errors++; $display("FAIL jmp_walk got %0d want %0d", address, i); end
         step();
      end
      checks++; if (address !== 10'd24 || pc_out !== 10'd23) begin errors++; $display("FAIL jmp_at24 got addr=%0d pc_out=%0d want 24 23", address, pc_out); end
      step();
      checks++; if (address !== 10'd21 || instr_valid !== 1'b0 || pc_out !== 10'd23) begin
         errors++; $display("FAIL jmp_bubble got addr=%0d valid=%b pc_out=%0d want 21 0 23", address, instr_valid, pc_out); end
      for (int i = 21; i < 24; i++) begin
         step();
         checks++; if (pc_out !== 10'(i) || instr_valid !== 1'b1) begin errors++; $display("FAIL jmp_loop got pc_out=%0d valid=%b want %0d 1", pc_out, instr_valid, i); end
      end
      step();
      checks++; if (instr_valid !== 1'b0 || pc_out === 10'd24) begin errors++; $display("FAIL jmp_not_fwd got valid=%b pc_out=%0d want 0 23", instr_valid, pc_out); end
   endtask

   // Program 2 hits the zero word at 36 and halts; a new start restarts program 0.
   task automatic test_halt();
      quiet_reset();
      pulse_start(2'd2);
      for (int i = 30; i < 36; i++) begin
         step();
         checks++; if (pc_out !== 10'(i) || instr_valid !== 1'b1) begin errors++; $display("FAIL halt_walk got pc_out=%0d valid=%b want %0d 1", pc_out, instr_valid, i); end
      end
      step();
      checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL halt_state got valid=%b busy=%b want 0 0", instr_valid, busy); end
      step();
      checks++; if (address !== 10'd36 || pc_out !== 10'd35) begin errors++; $display("FAIL halt_frozen got addr=%0d pc_out=%0d want 36 35", address, pc_out); end
      pulse_start(2'd0);
      checks++; if (address !== 10'd1 || busy !== 1'b1) begin errors++; $display("FAIL restart got addr=%0d busy=%b want 1 1", address, busy); end
      step();
      checks++; if (instr_out !== 32'h8C1F0001 || instr_valid !== 1'b1) begin errors++; $display("FAIL restart_instr got %h valid=%b want 8c1f0001 1", instr_out, instr_valid); end
   endtask

   // Fetch at PC_LIMIT delivers that word and halts with pc frozen there.
   task automatic test_pc_limit();
      redirect_valid = 1'b1; redirect_addr = 10'd78;
      step();
      redirect_valid = 1'b0;
      step();
      step();
      step();
      checks++; if (pc_out !== 10'd80 || instr_out !== 32'h8C000050 || busy !== 1'b0 || address !== 10'd80) begin
         errors++; $display("FAIL limit_halt got pc_out=%0d instr=%h busy=%b addr=%0d want 80 8c000050 0 80", pc_out, instr_out, busy, address); end
      step();
      checks++; if (instr_valid !== 1'b0 || address !== 10'd80) begin errors++; $display("FAIL limit_frozen got valid=%b addr=%0d want 0 80", instr_valid, address); end
   endtask

   task automatic test_sel_err();
      quiet_reset();
      pulse_start(2'd3);
      checks++; if (sel_err !== 1'b1 || busy !== 1'b0 || address !== 10'd0) begin
         errors++; $display("FAIL sel_err_set got sel_err=%b busy=%b addr=%0d want 1 0 0", sel_err, busy, address); end
      step();
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_sticky got %b want 1", sel_err); end
      pulse_start(2'd1);
      checks++; if (sel_err !== 1'b0 || busy !== 1'b1 || address !== 10'd15) begin
         errors++; $display("FAIL sel_err_clear got sel_err=%b busy=%b addr=%0d want 0 1 15", sel_err, busy, address); end
   endtask

   initial begin
      test_reset();
      test_prog0();
      test_redirect_stall();
      test_stall();
      test_async_reset();
      test_jump();
      test_halt();
      test_pc_limit();
      test_sel_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
